// File: rtl/spi_mem_burst_ctrl.sv
// spi_mem_burst_ctrl: turns a burst request into single-byte cmd/addr/en/valid memory transactions.
// Define SPI_MEM_TIMEOUT_EN to abort a transaction phase that waits TIMEOUT_CYCLES for mem_valid.
`ifndef CMD_WRITE
`define CMD_WRITE 2'd1
`endif
`ifndef CMD_READ
`define CMD_READ 2'd2
`endif
module spi_mem_burst_ctrl #(
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_byte,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [7:0]        rd_byte,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wr_data,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_en,
  input  logic              mem_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, PREP, ISSUE, RELEASE} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] addr_q, rem_q;
  logic              write_q, prep_go, tmo;
  assign req_ready = state_q == IDLE;
  assign busy      = !req_ready;
  assign prep_go   = state_q == PREP && !mem_valid && (write_q ? wr_valid : !rd_valid);
  assign wr_ready  = prep_go && write_q;
`ifdef SPI_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  assign tmo = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // counts only while the current phase is still waiting, so it restarts on every state entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= ((state_q == ISSUE && !mem_valid) || (state_q == RELEASE && mem_valid)) ? cnt_q + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      write_q     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_byte     <= '0;
      mem_cmd     <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_en      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (rd_valid && rd_ready) rd_valid <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          rem_q   <= req_len;
          write_q <= req_write;
          state_q <= PREP;
        end
        PREP: if (prep_go) begin
          if (write_q) mem_wr_data <= wr_byte;
          mem_cmd  <= write_q ? `CMD_WRITE : `CMD_READ;
          mem_addr <= addr_q;
          mem_en   <= 1'b1;
          state_q  <= ISSUE;
        end
        ISSUE: if (mem_valid) begin
          if (!write_q) begin
            rd_byte  <= mem_rd_data;
            rd_valid <= 1'b1;
          end
          mem_en  <= 1'b0;
          state_q <= RELEASE;
        end else if (tmo) begin
          mem_en  <= 1'b0;
          err     <= 1'b1;
          state_q <= IDLE;
        end
        RELEASE: if (!mem_valid) begin
          addr_q  <= addr_q + 1'b1;
          rem_q   <= rem_q - 1'b1;
          done    <= rem_q == ADDR_W'(1);
          state_q <= rem_q == ADDR_W'(1) ? IDLE : PREP;
        end else if (tmo) begin
          err     <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mem_burst_ctrl.sv
// tb_spi_mem_burst_ctrl: directed and random bursts against a memory model and array-based reference.
`ifndef CMD_WRITE
`define CMD_WRITE 2'd1
`endif
`ifndef CMD_READ
`define CMD_READ 2'd2
`endif
module tb_spi_mem_burst_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [5:0] req_addr = '0, req_len = '0;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_byte;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_byte;
  logic [1:0] mem_cmd;
  logic [5:0] mem_addr;
  logic [7:0] mem_wr_data, mem_rd_data;
  logic       mem_en, mem_valid, busy, done, err;

  always #5 clk = ~clk;

  spi_mem_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_byte(wr_byte),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_byte(rd_byte), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_en(mem_en), .mem_valid(mem_valid),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, clash = 0;
  logic [7:0]  mem_arr[64], ref_mem[64];
  logic [15:0] log_q[$];
  logic [7:0]  rd_q[$], wq[$], wbytes[$];
  bit dead = 0, force_v = 0, rd_rand = 0, rd_fix = 1;
  int lat = 0, drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // memory emulator: not reset by rst_n, random latency, valid held until en drops
  initial begin
    mem_valid = 1'b0; mem_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (force_v) mem_valid = 1'b1;
      else if (mem_valid) begin
        if (!mem_en) begin
          if (drop == 0) mem_valid = 1'b0; else drop--;
        end
      end else if (mem_en && !dead) begin
        if (lat == 0) begin
          if (mem_cmd == `CMD_WRITE) mem_arr[mem_addr] = mem_wr_data;
          else mem_rd_data = mem_arr[mem_addr];
          log_q.push_back({mem_cmd, mem_addr, mem_cmd == `CMD_WRITE ? mem_wr_data : mem_arr[mem_addr]});
          mem_valid = 1'b1;
          lat = $urandom_range(0, 3);
          drop = $urandom_range(0, 2);
        end else lat--;
      end
    end
  end

  initial begin
    wr_valid = 1'b0; wr_byte = '0;
    forever begin
      @(posedge clk);
      if (wr_valid && wr_ready && wq.size() > 0) void'(wq.pop_front());
      #1;
      wr_valid = wq.size() > 0 && $urandom_range(0, 3) != 0;
      wr_byte = wq.size() > 0 ? wq[0] : 8'h00;
    end
  end

  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rd_ready = rd_rand ? ($urandom_range(0, 1) == 1) : rd_fix;
    end
  end

  always @(posedge clk) begin
    if (rd_valid && rd_ready) rd_q.push_back(rd_byte);
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) clash++;
  end

  task automatic wait_done(input int d0, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin step(1); n++; end
    chk(tag, 32'(n < 3000), 1);
  endtask

  task automatic start_req(input bit w, input int a, input int l);
    req_write = w; req_addr = a[5:0]; req_len = l[5:0]; req_valid = 1'b1;
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic run_burst(input bit w, input int a, input int l);
    int d0, n, aa;
    log_q.delete(); rd_q.delete();
    d0 = done_cnt;
    if (w) for (int i = 0; i < l; i++) wq.push_back(wbytes[i]);
    chk("req_ready_idle", req_ready, 1);
    start_req(w, a, l);
    wait_done(d0, "done_timeout");
    n = 0;
    while (!w && rd_q.size() < l && n < 500) begin step(1); n++; end
    step(3);
    chk("done_once", done_cnt - d0, 1);
    chk("busy_after", busy, 0);
    chk("txn_count", log_q.size(), l);
    if (!w) chk("rd_count", rd_q.size(), l);
    for (int i = 0; i < l; i++) begin
      aa = (a + i) % 64;
      if (i < log_q.size())
        chk($sformatf("txn%0d", i), log_q[i], {w ? `CMD_WRITE : `CMD_READ, aa[5:0], w ? wbytes[i] : ref_mem[aa]});
      if (w) ref_mem[aa] = wbytes[i];
      else if (i < rd_q.size()) chk($sformatf("rd%0d", i), rd_q[i], ref_mem[aa]);
    end
  endtask

  initial begin
    int d0, e0, n;
    for (int i = 0; i < 64; i++) mem_arr[i] = 8'($urandom);
    ref_mem = mem_arr;
    step(3);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_mem_cmd", mem_cmd, 0);
    chk("rst_wr_ready", wr_ready, 0);
    rst_n = 1'b1;
    step(2);
    wbytes = '{8'hA1, 8'hA2, 8'hA3};
    run_burst(1, 5, 3);
    chk("t1_mem6", mem_arr[6], 8'hA2);
    run_burst(0, 5, 3);
    chk("t2_rd_last", rd_q.size() == 3 ? rd_q[2] : 8'h00, 8'hA3);
    wbytes = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_burst(1, 62, 4);
    run_burst(0, 0, 1);
    chk("t3_wrap_rd", rd_q.size() == 1 ? rd_q[0] : 8'h00, 8'd3);
    // back-pressure: second byte must not issue while the output register is full
    rd_fix = 0;
    step(1);
    log_q.delete(); rd_q.delete();
    d0 = done_cnt;
    start_req(0, 10, 2);
    step(20);
    chk("t4_txns", log_q.size(), 1);
    chk("t4_mem_en", mem_en, 0);
    chk("t4_rd_valid", rd_valid, 1);
    chk("t4_busy", busy, 1);
    rd_fix = 1;
    wait_done(d0, "t4_done");
    step(3);
    chk("t4_txns_end", log_q.size(), 2);
    chk("t4_rd_count", rd_q.size(), 2);
    chk("t4_rd1", rd_q.size() == 2 ? rd_q[1] : 8'h00, ref_mem[11]);
    // asynchronous reset mid-transaction, then a stale mem_valid after reset
    dead = 1;
    start_req(0, 20, 3);
    n = 0;
    while (!mem_en && n < 50) begin step(1); n++; end
    chk("t5_en_before", mem_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_en_async", mem_en, 0);
    chk("t5_ready_rst", req_ready, 1);
    force_v = 1;
    step(2);
    rst_n = 1'b1;
    dead = 0;
    step(1);
    chk("t5_ready_after", req_ready, 1);
    log_q.delete(); rd_q.delete();
    d0 = done_cnt;
    start_req(0, 5, 1);
    step(10);
    chk("t5_wait_stale", mem_en, 0);
    chk("t5_busy", busy, 1);
    chk("t5_no_txn", log_q.size(), 0);
    force_v = 0;
    wait_done(d0, "t5_done");
    step(3);
    chk("t5_rd", rd_q.size() == 1 ? rd_q[0] : 8'h00, ref_mem[5]);
    // memory that never answers
    dead = 1;
    d0 = done_cnt; e0 = err_cnt;
    start_req(0, 30, 2);
    n = 0;
    while (!mem_en && n < 50) begin step(1); n++; end
    chk("t6_issue", mem_en, 1);
    n = 0;
    while (!err && n < 200) begin step(1); n++; end
`ifdef SPI_MEM_TIMEOUT_EN
    chk("t6_err_delay", n, 64);
    chk("t6_ready_on_err", req_ready, 1);
    chk("t6_en_off", mem_en, 0);
    step(1);
    chk("t6_err_pulses", err_cnt - e0, 1);
    chk("t6_no_done", done_cnt - d0, 0);
`else
    chk("t6_busy_hang", busy, 1);
    chk("t6_en_held", mem_en, 1);
    chk("t6_no_err", err_cnt - e0, 0);
`endif
    dead = 0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    // full-size burst: length field 0 means 64 bytes
    wbytes.delete();
    for (int i = 0; i < 64; i++) wbytes.push_back(8'($urandom));
    run_burst(1, 17, 64);
    run_burst(0, 17, 64);
    rd_rand = 1;
    repeat (20) begin
      int w, a, l;
      w = $urandom_range(0, 1);
      a = $urandom_range(0, 63);
      l = $urandom_range(1, 6);
      wbytes.delete();
      for (int i = 0; i < l; i++) wbytes.push_back(8'($urandom));
      run_burst(w[0], a, l);
    end
    chk("done_err_clash", clash, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
